// File: rtl/bsg_link_pkg.sv
// ---------------------------------------------------------------------------
// bsg_link_pkg
//  Shared definitions for the BSG link credit path. Both the downstream token
//  scheduler and the upstream credit counter import this package so that
//  both ends agree on the decimation factor.
//  Contents:
//   token_sched_state_e        token scheduler FSM states
//   DOWN_LG_DECIMATION_DEFAULT log2 of the freed slots returned per token
//   DOWN_TOKEN_GAP_DEFAULT     minimum low cycles after each token pulse
//   TOKEN_GAP_W                width of the gap counter (gap range 0..15)
// ---------------------------------------------------------------------------
package bsg_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } token_sched_state_e;

  localparam int DOWN_LG_DECIMATION_DEFAULT = 2;
  localparam int DOWN_TOKEN_GAP_DEFAULT     = 1;
  localparam int TOKEN_GAP_W                = 4;

endpackage

// File: rtl/bsg_down_token_pulse_gen.sv
// ---------------------------------------------------------------------------
// bsg_down_token_pulse_gen
//  Token pulse sequencer. It emits one-cycle io_token_out pulses while tokens
//  are owed and the link is enabled, and holds the line low for at least
//  GAP_CYCLES cycles after each pulse.
//  Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   flush_i       in   synchronous clear back to IDLE
//   link_en_i     in   new pulses may start
//   pending_nz_i  in   at least one token is owed
//   io_token_out  out  registered token pulse
//   sent_o        out  decrement strobe, high during the SEND cycle
//   state_o       out  current FSM state
// ---------------------------------------------------------------------------
module bsg_down_token_pulse_gen
  import bsg_link_pkg::*;
#(
  parameter int GAP_CYCLES = DOWN_TOKEN_GAP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               link_en_i,
  input  logic               pending_nz_i,
  output logic               io_token_out,
  output logic               sent_o,
  output token_sched_state_e state_o
);

  localparam logic [TOKEN_GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? TOKEN_GAP_W'(GAP_CYCLES - 1) : '0;

  token_sched_state_e     r_state;
  logic                   r_token;
  logic [TOKEN_GAP_W-1:0] r_gap_cnt;

  logic w_start;
  assign w_start = link_en_i && pending_nz_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_token   <= 1'b0;
      r_gap_cnt <= '0;
    end else if (flush_i) begin
      r_state   <= IDLE;
      r_token   <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SEND;
            r_token <= 1'b1;
          end
        end
        SEND: begin
          r_token <= 1'b0;
          if (GAP_CYCLES > 0) begin
            r_state   <= GAP;
            r_gap_cnt <= GAP_LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        GAP: begin
          // Last gap cycle launches the next pulse directly, so a backlog
          // drains at one token per GAP_CYCLES+1 cycles instead of paying an
          // extra IDLE cycle per token.
          if (r_gap_cnt == '0) begin
            if (w_start) begin
              r_state <= SEND;
              r_token <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_token <= 1'b0;
        end
      endcase
    end
  end

  assign io_token_out = r_token;
  assign sent_o       = (r_state == SEND);
  assign state_o      = r_state;

endmodule

// File: rtl/bsg_down_token_sched.sv
// ---------------------------------------------------------------------------
// bsg_down_token_sched
//  Credit-return scheduler for the downstream channel. It counts buffer slots
//  freed by core dequeues, batches each 2**LG_DECIMATION of them into one
//  token, and has the pulse generator return owed tokens on io_token_out.
//  Ports:
//   clk               in   clock
//   rst_n             in   asynchronous active-low reset
//   link_en_i         in   tokens may be sent
//   flush_i           in   synchronous clear of all credit state
//   core_deq_i        in   one buffer slot freed this cycle
//   io_token_out      out  one-cycle token pulse to upstream
//   pending_tokens_o  out  tokens owed, not yet sent
//   credit_err_o      out  sticky: more slots freed than the buffer holds
//   busy_o            out  FSM active or tokens owed
// ---------------------------------------------------------------------------
module bsg_down_token_sched
  import bsg_link_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int LG_DECIMATION = DOWN_LG_DECIMATION_DEFAULT,
  parameter int GAP_CYCLES    = DOWN_TOKEN_GAP_DEFAULT,
  parameter int CNT_W         = $clog2((DEPTH >> LG_DECIMATION) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_en_i,
  input  logic             flush_i,
  input  logic             core_deq_i,
  output logic             io_token_out,
  output logic [CNT_W-1:0] pending_tokens_o,
  output logic             credit_err_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] MAX_PEND = CNT_W'(DEPTH >> LG_DECIMATION);

  logic [CNT_W-1:0]   r_pending;
  logic               r_err;
  logic               w_full;
  logic               w_deq_ok;
  logic               w_group_done;
  logic               w_sent;
  token_sched_state_e w_state;

  // With the owed count saturated, a further dequeue means upstream sent
  // more than the buffer holds; drop it rather than wrap the count.
  assign w_full   = (r_pending == MAX_PEND);
  assign w_deq_ok = core_deq_i && !w_full;

  generate
    if (LG_DECIMATION == 0) begin : g_no_frac
      assign w_group_done = w_deq_ok;
    end else begin : g_frac
      logic [LG_DECIMATION-1:0] r_frac;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_frac <= '0;
        end else if (flush_i) begin
          r_frac <= '0;
        end else if (w_deq_ok) begin
          r_frac <= r_frac + 1'b1;
        end
      end
      assign w_group_done = w_deq_ok && (&r_frac);
    end
  endgenerate

  // A completed group and a SEND-exit decrement on the same edge cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else if (flush_i) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= r_pending + CNT_W'(w_group_done) - CNT_W'(w_sent);
      if (core_deq_i && w_full) begin
        r_err <= 1'b1;
      end
    end
  end

  bsg_down_token_pulse_gen #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_pulse_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .link_en_i    (link_en_i),
    .pending_nz_i (r_pending != '0),
    .io_token_out (io_token_out),
    .sent_o       (w_sent),
    .state_o      (w_state)
  );

  assign pending_tokens_o = r_pending;
  assign credit_err_o     = r_err;
  assign busy_o           = (w_state != IDLE) || (r_pending != '0);

  a_pending_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_pending <= MAX_PEND);
  a_no_merge : assert property (@(posedge clk) disable iff (!rst_n)
    io_token_out |=> !io_token_out);
  a_token_in_send : assert property (@(posedge clk) disable iff (!rst_n)
    io_token_out |-> (w_state == SEND));

endmodule

// File: tb/tb_bsg_down_token_sched.sv
module tb_bsg_down_token_sched;

  logic       clk;
  logic       rst_n;
  logic       link_en_i;
  logic       flush_i;
  logic       core_deq_i;
  logic       io_token_out;
  logic [4:0] pending_tokens_o;
  logic       credit_err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic       s_tok;
  logic [4:0] s_pend;
  logic       s_err;
  logic       s_busy;

  bsg_down_token_sched #(
    .DEPTH         (64),
    .LG_DECIMATION (2),
    .GAP_CYCLES    (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .link_en_i        (link_en_i),
    .flush_i          (flush_i),
    .core_deq_i       (core_deq_i),
    .io_token_out     (io_token_out),
    .pending_tokens_o (pending_tokens_o),
    .credit_err_o     (credit_err_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // One cycle: apply deq, sample this cycle's outputs at negedge, advance.
  task automatic cyc(input logic deq);
    core_deq_i = deq;
    @(negedge clk);
    s_tok  = io_token_out;
    s_pend = pending_tokens_o;
    s_err  = credit_err_o;
    s_busy = busy_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(c[0]);
      n_checks++;
      if ({s_tok, s_pend, s_err, s_busy} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: tok=%b pend=%0d err=%b busy=%b required all 0",
                 c, s_tok, s_pend, s_err, s_busy);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0);
      n_checks++;
      if ({s_tok, s_pend, s_err, s_busy} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: tok=%b pend=%0d err=%b busy=%b required all 0",
                 c, s_tok, s_pend, s_err, s_busy);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_token();
    for (int c = 0; c < 10; c++) begin
      cyc(c <= 3);
      n_checks++;
      if (s_tok !== (c == 5)) begin
        n_fail++;
        $display("FAIL single_tok cyc %0d: tok=%b required %b", c, s_tok, (c == 5));
      end
      if (c == 4 || c == 5) begin
        n_checks++;
        if (s_pend !== 5'd1) begin
          n_fail++;
          $display("FAIL single_pend cyc %0d: pend=%0d required 1", c, s_pend);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (s_pend !== 5'd0) begin
          n_fail++;
          $display("FAIL single_pend_after cyc %0d: pend=%0d required 0", c, s_pend);
        end
      end
    end
    n_checks++;
    if (s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_end: busy=%b required 0", s_busy);
    end
    $display("test_single_token done");
  endtask

  task automatic test_partial_group();
    for (int c = 0; c < 21; c++) begin
      cyc(c <= 2 || c == 13);
      n_checks++;
      if (s_tok !== (c == 15)) begin
        n_fail++;
        $display("FAIL partial_tok cyc %0d: tok=%b required %b", c, s_tok, (c == 15));
      end
      if (c == 12) begin
        n_checks++;
        if ({s_pend, s_busy} !== 6'd0) begin
          n_fail++;
          $display("FAIL partial_idle cyc %0d: pend=%0d busy=%b required 0/0", c, s_pend, s_busy);
        end
      end
    end
    $display("test_partial_group done");
  endtask

  task automatic test_back_to_back();
    int   pulses = 0;
    logic prev   = 1'b0;
    logic exp_tok;
    for (int c = 0; c < 46; c++) begin
      cyc(c <= 31);
      exp_tok = (c >= 5) && (c <= 33) && (((c - 5) % 4) == 0);
      n_checks++;
      if (s_tok !== exp_tok) begin
        n_fail++;
        $display("FAIL b2b_tok cyc %0d: tok=%b required %b", c, s_tok, exp_tok);
      end
      n_checks++;
      if (prev && s_tok) begin
        n_fail++;
        $display("FAIL b2b_merge cyc %0d: tok=1 after tok=1 required a low cycle", c);
      end
      if (s_tok === 1'b1) pulses++;
      prev = s_tok;
    end
    n_checks++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL b2b_count: pulses=%0d required 8", pulses);
    end
    n_checks++;
    if (s_pend !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_pend_end: pend=%0d required 0", s_pend);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_link_disable();
    logic exp_tok;
    link_en_i = 1'b0;
    for (int c = 0; c < 33; c++) begin
      if (c == 20) link_en_i = 1'b1;
      cyc(c <= 15);
      exp_tok = (c == 21) || (c == 23) || (c == 25) || (c == 27);
      n_checks++;
      if (s_tok !== exp_tok) begin
        n_fail++;
        $display("FAIL link_tok cyc %0d: tok=%b required %b", c, s_tok, exp_tok);
      end
      if (c == 19) begin
        n_checks++;
        if (s_pend !== 5'd4) begin
          n_fail++;
          $display("FAIL link_pend_held: pend=%0d required 4", s_pend);
        end
      end
      if (c == 22) begin
        n_checks++;
        if (s_pend !== 5'd3) begin
          n_fail++;
          $display("FAIL link_pend_drain: pend=%0d required 3", s_pend);
        end
      end
    end
    n_checks++;
    if ({s_pend, s_busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL link_end: pend=%0d busy=%b required 0/0", s_pend, s_busy);
    end
    $display("test_link_disable done");
  endtask

  task automatic test_overflow_flush();
    link_en_i = 1'b0;
    for (int c = 0; c < 66; c++) begin
      cyc(c <= 64);
      n_checks++;
      if (s_tok !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_tok cyc %0d: tok=%b required 0", c, s_tok);
      end
      if (c == 64) begin
        n_checks++;
        if ({s_pend, s_err} !== {5'd16, 1'b0}) begin
          n_fail++;
          $display("FAIL ovf_full: pend=%0d err=%b required 16/0", s_pend, s_err);
        end
      end
      if (c == 65) begin
        n_checks++;
        if ({s_pend, s_err} !== {5'd16, 1'b1}) begin
          n_fail++;
          $display("FAIL ovf_err: pend=%0d err=%b required 16/1", s_pend, s_err);
        end
      end
    end
    flush_i = 1'b1;
    cyc(1'b1);
    flush_i = 1'b0;
    cyc(1'b0);
    n_checks++;
    if ({s_tok, s_pend, s_err, s_busy} !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_clear: tok=%b pend=%0d err=%b busy=%b required all 0",
               s_tok, s_pend, s_err, s_busy);
    end
    // Flush-cycle deq must be discarded: three more deqs must not give a token.
    link_en_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc(c <= 2 || c == 8);
      n_checks++;
      if (s_tok !== (c == 10)) begin
        n_fail++;
        $display("FAIL flush_frac_tok cyc %0d: tok=%b required %b", c, s_tok, (c == 10));
      end
    end
    $display("test_overflow_flush done");
  endtask

  task automatic test_reset_mid_pulse();
    link_en_i = 1'b1;
    for (int c = 0; c < 5; c++) cyc(c <= 3);
    core_deq_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({io_token_out, pending_tokens_o} !== {1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL rst_mid_setup: tok=%b pend=%0d required 1/1", io_token_out, pending_tokens_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({io_token_out, pending_tokens_o, credit_err_o, busy_o} !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: tok=%b pend=%0d err=%b busy=%b required all 0",
               io_token_out, pending_tokens_o, credit_err_o, busy_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0);
      n_checks++;
      if ({s_tok, s_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_mid_after cyc %0d: tok=%b busy=%b required 0/0", c, s_tok, s_busy);
      end
    end
    $display("test_reset_mid_pulse done");
  endtask

  initial begin
    rst_n      = 1'b0;
    link_en_i  = 1'b1;
    flush_i    = 1'b0;
    core_deq_i = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_token();
    test_partial_group();
    test_back_to_back();
    test_link_disable();
    test_overflow_flush();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
